// File: rtl/rng_pkg.sv
// Shared types and helpers for the random-number arbiter: FSM state,
// seed sanitising and the round-robin winner search.
package rng_pkg;

    // Arbiter phases: load seed, step the LFSR without serving, serve requests.
    typedef enum logic [1:0] {
        INIT   = 2'd0,
        WARMUP = 2'd1,
        SERVE  = 2'd2
    } rng_state_e;

    // Upper bounds the helper functions are written against.
    localparam int unsigned RrMaxReq = 32;
    localparam int unsigned RrIdxW   = 5;
    localparam int unsigned SeedMaxW = 64;

    // Round-robin search result: found is low when no request is pending.
    typedef struct packed {
        logic              found;
        logic [RrIdxW-1:0] idx;
    } rr_pick_t;

    // An all-ones seed is the lock-up state of an XNOR LFSR; clear bit 0 to escape it.
    // Only the low 'width' bits of the seed are meaningful.
    function automatic logic [SeedMaxW-1:0] sanitize_seed(
        input logic [SeedMaxW-1:0] seed,
        input int unsigned         width
    );
        logic                all_ones;
        logic [SeedMaxW-1:0] result;
        all_ones = 1'b1;
        for (int unsigned i = 0; i < SeedMaxW; i++) begin
            if (i < width && !seed[i]) begin
                all_ones = 1'b0;
            end
        end
        result = seed;
        if (all_ones) begin
            result[0] = 1'b0;
        end
        return result;
    endfunction

    // First set request bit searching upward from last+1, wrapping at n.
    // The previous winner is searched last, which gives the round-robin fairness.
    function automatic rr_pick_t rr_pick(
        input logic [RrMaxReq-1:0] req,
        input int unsigned         last,
        input int unsigned         n
    );
        rr_pick_t    r;
        int unsigned idx;
        r = '0;
        for (int unsigned i = 1; i <= RrMaxReq; i++) begin
            if (!r.found && i <= n) begin
                idx = (last + i) % n;
                if (req[idx[RrIdxW-1:0]]) begin
                    r.found = 1'b1;
                    r.idx   = idx[RrIdxW-1:0];
                end
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/lfsr.sv
// Fibonacci LFSR with XNOR feedback. rst is synchronous and loads the seed;
// en advances one step. The all-ones word is the lock-up state.
module lfsr #(
    parameter int unsigned      Width   = 32,
    parameter logic [Width-1:0] TapMask = 32'b10000000001000000000000000000011
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [Width-1:0] seed,
    input  logic             en,
    output logic [Width-1:0] q
);

    logic [Width-1:0] q_r;

    // Load the seed on rst, otherwise shift left with the XNOR of the tapped bits.
    always_ff @(posedge clk) begin
        if (rst) begin
            q_r <= seed;
        end else if (en) begin
            q_r <= {q_r[Width-2:0], ~^(q_r & TapMask)};
        end
    end

    assign q = q_r;

endmodule

// File: rtl/rng_arbiter.sv
// Shares one LFSR between NumReq requesters. After every seed load the LFSR
// is stepped WarmupCycles times, then one requester per cycle is granted in
// round-robin order. The LFSR advances only on a grant, so every word is
// handed out exactly once between seed loads.
//
// Handshakes: a grant is ack[i] high in a cycle; rsp_data is the word being
// consumed and the LFSR steps at the closing edge. The reseed handshake fires
// on a cycle where reseed_valid and reseed_ready are both high; reseed_seed is
// sampled on that edge and reseed_valid must stay high until then. Reseed has
// priority over grants in the same cycle.
module rng_arbiter
    import rng_pkg::*;
#(
    parameter int unsigned      NumReq       = 4,
    parameter int unsigned      Width        = 32,
    parameter logic [Width-1:0] TapMask      = 32'b10000000001000000000000000000011,
    parameter logic [Width-1:0] ResetSeed    = 32'h1,
    parameter int unsigned      WarmupCycles = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NumReq-1:0] req,
    output logic [NumReq-1:0] ack,
    output logic [Width-1:0]  rsp_data,
    input  logic              reseed_valid,
    input  logic [Width-1:0]  reseed_seed,
    output logic              reseed_ready,
    output logic              busy
);

    localparam int unsigned IdxW = (NumReq > 1) ? $clog2(NumReq) : 1;
    localparam int unsigned CntW = (WarmupCycles > 0) ? $clog2(WarmupCycles + 1) : 1;

    // Last warm-up count value; only reachable when WarmupCycles > 0.
    localparam logic [CntW-1:0]  WarmLast     = CntW'((WarmupCycles > 0) ? WarmupCycles - 1 : 0);
    localparam logic [Width-1:0] ResetSeedSan = Width'(sanitize_seed(SeedMaxW'(ResetSeed), Width));
    localparam logic [IdxW-1:0]  RrLastReset  = IdxW'(NumReq - 1);

    rng_state_e       state;
    logic [Width-1:0] seed_q;
    logic [CntW-1:0]  warm_cnt;
    logic [IdxW-1:0]  rr_last;

    rr_pick_t         pick;
    logic             serve;
    logic             reseed_fire;
    logic             grant_fire;
    logic             lfsr_load;
    logic             lfsr_en;
    logic [Width-1:0] reseed_san;

    assign serve       = (state == SERVE);
    assign reseed_fire = serve && reseed_valid;
    assign pick        = rr_pick(RrMaxReq'(req), 32'(rr_last), NumReq);
    assign grant_fire  = serve && !reseed_valid && pick.found;
    assign lfsr_load   = (state == INIT);
    assign lfsr_en     = (state == WARMUP) || grant_fire;
    assign reseed_san  = Width'(sanitize_seed(SeedMaxW'(reseed_seed), Width));

    assign ack          = grant_fire ? (NumReq'(1) << pick.idx) : '0;
    assign reseed_ready = serve;
    assign busy         = !serve;

    // Phase sequencing, warm-up counting, seed capture and round-robin pointer update.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= INIT;
            seed_q   <= ResetSeedSan;
            warm_cnt <= '0;
            rr_last  <= RrLastReset;
        end else begin
            case (state)
                INIT: begin
                    warm_cnt <= '0;
                    state    <= (WarmupCycles > 0) ? WARMUP : SERVE;
                end
                WARMUP: begin
                    warm_cnt <= warm_cnt + 1'b1;
                    if (warm_cnt == WarmLast) begin
                        state <= SERVE;
                    end
                end
                SERVE: begin
                    if (reseed_valid) begin
                        seed_q <= reseed_san;
                        state  <= INIT;
                    end else if (pick.found) begin
                        rr_last <= IdxW'(pick.idx);
                    end
                end
                default: begin
                    state <= INIT;
                end
            endcase
        end
    end

    lfsr #(
        .Width  (Width),
        .TapMask(TapMask)
    ) u_lfsr (
        .clk (clk),
        .rst (lfsr_load),
        .seed(seed_q),
        .en  (lfsr_en),
        .q   (rsp_data)
    );

endmodule

// File: tb/tb_rng_arbiter.sv
// Bench for rng_arbiter: two instances, one without warm-up and one with a
// three-step warm-up, driven one after the other. Expected grants are pushed
// when the stimulus is applied and checked by a negedge monitor.
module tb_rng_arbiter;

    logic clk;
    logic rst0, rst3;
    logic [3:0] req0, req3, ack0, ack3, rsp0, rsp3, rs0, rs3;
    logic rv0, rv3, rr0, rr3, busy0, busy3;

    int n_assert = 0;
    int n_fail   = 0;

    logic [7:0] exp_q0[$];
    logic [7:0] exp_q3[$];
    logic [7:0] e0, e3;
    logic [3:0] m0, m3;

    rng_arbiter #(
        .NumReq(4), .Width(4), .TapMask(4'b1100), .ResetSeed(4'b0001), .WarmupCycles(0)
    ) dut0 (
        .clk(clk), .rst(rst0), .req(req0), .ack(ack0), .rsp_data(rsp0),
        .reseed_valid(rv0), .reseed_seed(rs0), .reseed_ready(rr0), .busy(busy0)
    );

    rng_arbiter #(
        .NumReq(4), .Width(4), .TapMask(4'b1100), .ResetSeed(4'b0001), .WarmupCycles(3)
    ) dut3 (
        .clk(clk), .rst(rst3), .req(req3), .ack(ack3), .rsp_data(rsp3),
        .reseed_valid(rv3), .reseed_seed(rs3), .reseed_ready(rr3), .busy(busy3)
    );

    // Clock
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Watchdog
    initial begin
        #200000;
        $display("FAIL watchdog: observed no end of test, required finish before 200000");
        $fatal(1, "timeout");
    end

    // XNOR of bits 3 and 2 shifted into bit 0.
    function automatic logic [3:0] lfsr_next(input logic [3:0] q);
        return {q[2:0], ~(q[3] ^ q[2])};
    endfunction

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h required %h", tag, obs, exp);
        end
    endtask

    task automatic cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic push0(input logic [3:0] a);
        exp_q0.push_back({a, m0});
        m0 = lfsr_next(m0);
    endtask

    task automatic push3(input logic [3:0] a);
        exp_q3.push_back({a, m3});
        m3 = lfsr_next(m3);
    endtask

    // Scoreboard monitor: every ack must match the next expected {ack, data}.
    always @(negedge clk) begin
        if (ack0 !== 4'b0000) begin
            n_assert++;
            assert (exp_q0.size() > 0) else begin
                n_fail++;
                $error("FAIL ack0_unexpected: observed ack %b data %h required no ack", ack0, rsp0);
            end
            if (exp_q0.size() > 0) begin
                e0 = exp_q0.pop_front();
                chk("grant0", {ack0, rsp0}, e0);
            end
        end
        if (ack3 !== 4'b0000) begin
            n_assert++;
            assert (exp_q3.size() > 0) else begin
                n_fail++;
                $error("FAIL ack3_unexpected: observed ack %b data %h required no ack", ack3, rsp3);
            end
            if (exp_q3.size() > 0) begin
                e3 = exp_q3.pop_front();
                chk("grant3", {ack3, rsp3}, e3);
            end
        end
    end

    initial begin
        rst0 = 1'b1; rst3 = 1'b1;
        req0 = '0; req3 = '0; rv0 = 1'b0; rv3 = 1'b0; rs0 = '0; rs3 = '0;
        m0 = '0; m3 = '0;

        // Reset values
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_ack0", 8'(ack0), 8'h00);
        chk("rst_busy0", 8'(busy0), 8'h01);
        chk("rst_ready0", 8'(rr0), 8'h00);
        chk("rst_ack3", 8'(ack3), 8'h00);
        chk("rst_busy3", 8'(busy3), 8'h01);
        chk("rst_ready3", 8'(rr3), 8'h00);

        // Single requester, no warm-up: 0001 0011 0111 1110
        cycles(1);
        rst0 = 1'b0; req0 = 4'b0001; m0 = 4'b0001;
        repeat (4) push0(4'b0001);
        @(negedge clk);
        chk("t1_init_busy", 8'(busy0), 8'h01);
        @(negedge clk);
        chk("t1_serve_busy", 8'(busy0), 8'h00);
        chk("t1_serve_ready", 8'(rr0), 8'h01);
        cycles(4);
        req0 = 4'b0000;

        // All requesting after a fresh reset: order 0,1,2,3,0
        rst0 = 1'b1;
        cycles(1);
        rst0 = 1'b0; req0 = 4'b1111; m0 = 4'b0001;
        push0(4'b0001); push0(4'b0010); push0(4'b0100); push0(4'b1000); push0(4'b0001);
        @(negedge clk);
        chk("t2_init_busy", 8'(busy0), 8'h01);
        cycles(6);
        req0 = 4'b0000;

        // Idle: LFSR holds, then requester 2 gets the following word
        cycles(5);
        req0 = 4'b0100;
        push0(4'b0100);
        cycles(1);
        req0 = 4'b0000;

        // Reseed with all-ones beats a pending request; seed becomes 1110
        cycles(1);
        req0 = 4'b0010; rv0 = 1'b1; rs0 = 4'b1111;
        @(negedge clk);
        chk("t4_reseed_noack", 8'(ack0), 8'h00);
        chk("t4_reseed_ready", 8'(rr0), 8'h01);
        cycles(1);
        rv0 = 1'b0;
        m0 = 4'b1110;
        push0(4'b0010);
        @(negedge clk);
        chk("t4_init_busy", 8'(busy0), 8'h01);
        chk("t4_init_ready", 8'(rr0), 8'h00);
        cycles(2);
        req0 = 4'b0000;
        cycles(2);

        // Warm-up of three: busy four cycles, first word 1110
        rst3 = 1'b0; req3 = 4'b0001; m3 = 4'b0001;
        repeat (3) m3 = lfsr_next(m3);
        push3(4'b0001);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("t3_warm_busy", 8'(busy3), 8'h01);
            chk("t3_warm_noack", 8'(ack3), 8'h00);
        end
        @(negedge clk);
        chk("t3_serve_busy", 8'(busy3), 8'h00);
        cycles(1);
        req3 = 4'b0000;

        // Reseed to 0011, then reset in the middle of warm-up
        cycles(1);
        rv3 = 1'b1; rs3 = 4'b0011; req3 = 4'b0001;
        cycles(1);
        rv3 = 1'b0;
        cycles(2);
        #2 rst3 = 1'b1;
        #1;
        chk("t5_async_ack", 8'(ack3), 8'h00);
        chk("t5_async_busy", 8'(busy3), 8'h01);
        chk("t5_async_ready", 8'(rr3), 8'h00);
        cycles(1);
        rst3 = 1'b0; m3 = 4'b0001;
        repeat (3) m3 = lfsr_next(m3);
        push3(4'b0001); push3(4'b0001);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("t5_rewarm_busy", 8'(busy3), 8'h01);
        end
        cycles(3);
        req3 = 4'b0000;

        // All expected grants consumed
        cycles(2);
        @(negedge clk);
        chk("q0_drained", 8'(exp_q0.size()), 8'h00);
        chk("q3_drained", 8'(exp_q3.size()), 8'h00);
        chk("t5_end_ready", 8'(rr3), 8'h01);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
